// File: rtl/fixed_mult_seq.sv
`timescale 1ns/1ps
// fixed_mult_seq: iterative fixed-point multiplier (Q format, FRAC_BIT_COUNT
// fractional bits). Consumes BITS_PER_CYCLE multiplicand bits per clock on
// operand magnitudes, then applies sign, rounding, shift and saturation in
// a single normalisation cycle. start/busy/ready handshake to the controller.
module fixed_mult_seq #(
   parameter int DATA_WIDTH     = 32,
   parameter int FRAC_BIT_COUNT = DATA_WIDTH / 2,
   parameter int BITS_PER_CYCLE = 1,
   parameter bit SIGNED         = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] multiplier,
   input  logic [DATA_WIDTH-1:0] multiplicand,
   input  logic                  round_en,
   input  logic                  sat_en,
   output logic                  busy,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] product,
   output logic                  overflow
);

   localparam int W  = DATA_WIDTH;
   localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = 2 * DATA_WIDTH;
   localparam int EW = 2 * DATA_WIDTH + 1;

   // Rounding constant is half an output LSB; zero when there is no fraction.
   localparam int            RND_SHIFT = (FRAC_BIT_COUNT > 0) ? FRAC_BIT_COUNT - 1 : 0;
   localparam logic [EW-1:0] RND_CONST = (FRAC_BIT_COUNT > 0) ? (EW'(1) << RND_SHIFT) : '0;

   localparam logic [W-1:0] SAT_MAX = SIGNED ? {1'b0, {(W-1){1'b1}}} : {W{1'b1}};
   localparam logic [W-1:0] SAT_MIN = SIGNED ? {1'b1, {(W-1){1'b0}}} : {W{1'b0}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      NORM
   } state_t;

   state_t         state;
   logic [CW-1:0]  count;
   logic [W-1:0]   mag_a;
   logic [W-1:0]   mag_b;
   logic [PW-1:0]  acc;
   logic           neg;
   logic           rnd_q;
   logic           sat_q;

   logic [PW-1:0]        partial;
   logic [PW-1:0]        partial_shifted;
   logic [PW-1:0]        p_full;
   logic signed [EW-1:0] p_ext;
   logic signed [EW-1:0] p_rnd;
   logic signed [EW-1:0] r_val;
   logic                 out_of_range;
   logic [W-1:0]         norm_product;

   // Partial product of |A| with the next multiplicand digit, placed at its weight.
   always_comb begin
      partial         = PW'(mag_a) * PW'(mag_b[BITS_PER_CYCLE-1:0]);
      partial_shifted = partial << (int'(count) * BITS_PER_CYCLE);
   end

   // Normalisation: restore sign, round, rescale and range-check the product.
   always_comb begin
      p_full = neg ? (~acc + 1'b1) : acc;
      p_ext  = SIGNED ? {p_full[PW-1], p_full} : {1'b0, p_full};
      p_rnd  = rnd_q ? (p_ext + RND_CONST) : p_ext;
      r_val  = p_rnd >>> FRAC_BIT_COUNT;
      if (SIGNED) begin
         out_of_range = !((&r_val[EW-1:W-1]) || !(|r_val[EW-1:W-1]));
      end else begin
         out_of_range = |r_val[EW-1:W];
      end
      if (out_of_range && sat_q) begin
         norm_product = r_val[EW-1] ? SAT_MIN : SAT_MAX;
      end else begin
         norm_product = r_val[W-1:0];
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         acc      <= '0;
         neg      <= 1'b0;
         rnd_q    <= 1'b0;
         sat_q    <= 1'b0;
         busy     <= 1'b0;
         ready    <= 1'b0;
         product  <= '0;
         overflow <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mag_a <= (SIGNED && multiplier[W-1])   ? (~multiplier + 1'b1)   : multiplier;
                  mag_b <= (SIGNED && multiplicand[W-1]) ? (~multiplicand + 1'b1) : multiplicand;
                  neg   <= SIGNED && (multiplier[W-1] ^ multiplicand[W-1]);
                  rnd_q <= round_en;
                  sat_q <= sat_en;
                  acc   <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               acc   <= acc + partial_shifted;
               mag_b <= mag_b >> BITS_PER_CYCLE;
               if (count == CW'(N - 1)) begin
                  state <= NORM;
               end else begin
                  count <= count + 1'b1;
               end
            end
            NORM: begin
               product  <= norm_product;
               overflow <= out_of_range;
               ready    <= 1'b1;
               busy     <= 1'b0;
               count    <= '0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_mult_seq.sv
`timescale 1ns/1ps
// Testbench for fixed_mult_seq: two instances (signed Q16.16 with one bit per
// cycle, unsigned Q16.16 with four bits per cycle). Stimulus pushes the
// hand-computed result and its due cycle; per-instance monitors pop on ready.
module tb_fixed_mult_seq;

   localparam int LAT0 = 33;
   localparam int LAT1 = 9;

   typedef struct {
      logic [31:0] prod;
      logic        ov;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   run0 = 0;
   int   run1 = 0;
   exp_t q0[$];
   exp_t q1[$];

   logic        reset0, start0, rnd0, sat0, busy0, ready0, ov0;
   logic [31:0] a0, b0, prod0;
   logic        reset1, start1, rnd1, sat1, busy1, ready1, ov1;
   logic [31:0] a1, b1, prod1;

   fixed_mult_seq dut0 (
      .clk(clk), .reset(reset0), .start(start0),
      .multiplier(a0), .multiplicand(b0),
      .round_en(rnd0), .sat_en(sat0),
      .busy(busy0), .ready(ready0), .product(prod0), .overflow(ov0)
   );

   fixed_mult_seq #(
      .DATA_WIDTH(32), .FRAC_BIT_COUNT(16), .BITS_PER_CYCLE(4), .SIGNED(1'b0)
   ) dut1 (
      .clk(clk), .reset(reset1), .start(start1),
      .multiplier(a1), .multiplicand(b1),
      .round_en(rnd1), .sat_en(sat1),
      .busy(busy1), .ready(ready1), .product(prod1), .overflow(ov1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Drives one request at the current negedge; optionally records the expected result.
   task automatic applyStimulus(input int dut, input logic [31:0] a, input logic [31:0] b,
                                input logic rnd, input logic sat,
                                input logic [31:0] ep, input logic eov, input bit expect_result);
      exp_t e;
      e.prod = ep;
      e.ov   = eov;
      if (dut == 0) begin
         a0 = a; b0 = b; rnd0 = rnd; sat0 = sat; start0 = 1'b1;
         e.due = cyc + LAT0 + 1;
         if (expect_result) q0.push_back(e);
      end else begin
         a1 = a; b1 = b; rnd1 = rnd; sat1 = sat; start1 = 1'b1;
         e.due = cyc + LAT1 + 1;
         if (expect_result) q1.push_back(e);
      end
      @(negedge clk);
      if (dut == 0) begin
         start0 = 1'b0; a0 = 32'hDEADBEEF; b0 = 32'h12345678; rnd0 = ~rnd; sat0 = ~sat;
      end else begin
         start1 = 1'b0; a1 = 32'hDEADBEEF; b1 = 32'h12345678; rnd1 = ~rnd; sat1 = ~sat;
      end
   endtask

   task automatic wait_drain(input int dut);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (dut == 0) done = (q0.size() == 0) && !busy0;
         else          done = (q1.size() == 0) && !busy1;
      end
      if (!done) begin
         checks++; errors++;
         $display("[TB] FAIL drain_timeout dut%0d: got still pending expected idle", dut);
      end
   endtask

   task automatic wait_ready(input int dut);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = (dut == 0) ? ready0 : ready1;
      end
      if (!done) begin
         checks++; errors++;
         $display("[TB] FAIL ready_timeout dut%0d: got no ready expected ready", dut);
      end
   endtask

   // Monitor for the signed instance: compares each ready against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (busy0) run0++;
      else if (!ready0) run0 = 0;
      if (ready0) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL dut0_unexpected_ready: got ready=1 expected ready=0");
         end else begin
            e = q0.pop_front();
            checkOutput("dut0_product", 64'(prod0), 64'(e.prod));
            checkOutput("dut0_overflow", 64'(ov0), 64'(e.ov));
            checkOutput("dut0_ready_cycle", 64'(cyc), 64'(e.due));
            checkOutput("dut0_busy_cycles", 64'(run0), 64'(LAT0));
         end
         run0 = 0;
      end
   end

   // Monitor for the unsigned four-bits-per-cycle instance.
   always @(negedge clk) begin
      exp_t e;
      if (busy1) run1++;
      else if (!ready1) run1 = 0;
      if (ready1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL dut1_unexpected_ready: got ready=1 expected ready=0");
         end else begin
            e = q1.pop_front();
            checkOutput("dut1_product", 64'(prod1), 64'(e.prod));
            checkOutput("dut1_overflow", 64'(ov1), 64'(e.ov));
            checkOutput("dut1_ready_cycle", 64'(cyc), 64'(e.due));
            checkOutput("dut1_busy_cycles", 64'(run1), 64'(LAT1));
         end
         run1 = 0;
      end
   end

   // Hard stop if something stalls beyond all per-wait bounds.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset0 = 1'b1; start0 = 1'b0; a0 = '0; b0 = '0; rnd0 = 1'b0; sat0 = 1'b0;
      reset1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; rnd1 = 1'b0; sat1 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst0_busy", 64'(busy0), 64'd0);
      checkOutput("rst0_ready", 64'(ready0), 64'd0);
      checkOutput("rst0_product", 64'(prod0), 64'd0);
      checkOutput("rst0_overflow", 64'(ov0), 64'd0);
      checkOutput("rst1_busy", 64'(busy1), 64'd0);
      checkOutput("rst1_ready", 64'(ready1), 64'd0);
      checkOutput("rst1_product", 64'(prod1), 64'd0);
      checkOutput("rst1_overflow", 64'(ov1), 64'd0);
      reset0 = 1'b0; reset1 = 1'b0;
      @(negedge clk);

      // Signed instance: arithmetic, rounding, saturation and wrap
      applyStimulus(0, 32'h00018000, 32'h00020000, 0, 0, 32'h00030000, 0, 1); wait_drain(0);
      applyStimulus(0, 32'hFFFE8000, 32'h00020000, 0, 0, 32'hFFFD0000, 0, 1); wait_drain(0);
      applyStimulus(0, 32'h80000000, 32'h80000000, 0, 1, 32'h7FFFFFFF, 1, 1); wait_drain(0);
      applyStimulus(0, 32'h00000001, 32'h00008000, 0, 0, 32'h00000000, 0, 1); wait_drain(0);
      applyStimulus(0, 32'h00000001, 32'h00008000, 1, 0, 32'h00000001, 0, 1); wait_drain(0);
      applyStimulus(0, 32'h7FFF0000, 32'h00020000, 0, 1, 32'h7FFFFFFF, 1, 1); wait_drain(0);
      applyStimulus(0, 32'h7FFF0000, 32'h00020000, 0, 0, 32'hFFFE0000, 1, 1); wait_drain(0);
      applyStimulus(0, 32'h80000000, 32'h00020000, 0, 1, 32'h80000000, 1, 1); wait_drain(0);
      applyStimulus(0, 32'h80000000, 32'h00020000, 0, 0, 32'h00000000, 1, 1); wait_drain(0);

      // Start while busy is ignored; start during the ready cycle is accepted
      applyStimulus(0, 32'h00018000, 32'h00020000, 0, 0, 32'h00030000, 0, 1);
      repeat (5) @(negedge clk);
      applyStimulus(0, 32'h00040000, 32'h00040000, 0, 0, 32'h0, 0, 0);
      wait_drain(0);
      applyStimulus(0, 32'hFFFE8000, 32'h00020000, 0, 0, 32'hFFFD0000, 0, 1);
      wait_ready(0);
      applyStimulus(0, 32'h00018000, 32'h00020000, 0, 0, 32'h00030000, 0, 1);
      wait_drain(0);

      // Reset at CALC cycle 10 discards the operation and clears the result
      applyStimulus(0, 32'h00018000, 32'h00020000, 0, 0, 32'h0, 0, 0);
      repeat (9) @(negedge clk);
      reset0 = 1'b1;
      @(negedge clk);
      reset0 = 1'b0;
      checkOutput("midrst0_busy", 64'(busy0), 64'd0);
      checkOutput("midrst0_ready", 64'(ready0), 64'd0);
      checkOutput("midrst0_product", 64'(prod0), 64'd0);
      repeat (45) @(negedge clk);

      // Reset together with start wins
      reset0 = 1'b1; start0 = 1'b1; a0 = 32'h00018000; b0 = 32'h00020000;
      @(negedge clk);
      reset0 = 1'b0; start0 = 1'b0;
      checkOutput("rst_start0_busy", 64'(busy0), 64'd0);
      repeat (40) @(negedge clk);
      applyStimulus(0, 32'h00018000, 32'h00020000, 1, 1, 32'h00030000, 0, 1); wait_drain(0);

      // Unsigned instance, four bits per cycle
      applyStimulus(1, 32'h00018000, 32'h00020000, 0, 0, 32'h00030000, 0, 1); wait_drain(1);
      applyStimulus(1, 32'h7FFF0000, 32'h00020000, 0, 1, 32'hFFFE0000, 0, 1); wait_drain(1);
      applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 1, 1); wait_drain(1);
      applyStimulus(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFE0000, 1, 1); wait_drain(1);
      applyStimulus(1, 32'h00000001, 32'h00008000, 0, 0, 32'h00000000, 0, 1); wait_drain(1);
      applyStimulus(1, 32'h00000001, 32'h00008000, 1, 0, 32'h00000001, 0, 1); wait_drain(1);
      applyStimulus(1, 32'hFFFE8000, 32'h00020000, 0, 0, 32'hFFFD0000, 1, 1); wait_drain(1);

      applyStimulus(1, 32'h00018000, 32'h00020000, 0, 0, 32'h00030000, 0, 1);
      repeat (3) @(negedge clk);
      applyStimulus(1, 32'h00040000, 32'h00040000, 0, 0, 32'h0, 0, 0);
      wait_ready(1);
      applyStimulus(1, 32'h00000001, 32'h00008000, 1, 0, 32'h00000001, 0, 1);
      wait_drain(1);

      applyStimulus(1, 32'h00018000, 32'h00020000, 0, 0, 32'h0, 0, 0);
      repeat (3) @(negedge clk);
      reset1 = 1'b1;
      @(negedge clk);
      reset1 = 1'b0;
      checkOutput("midrst1_busy", 64'(busy1), 64'd0);
      checkOutput("midrst1_ready", 64'(ready1), 64'd0);
      checkOutput("midrst1_product", 64'(prod1), 64'd0);
      repeat (20) @(negedge clk);

      checkOutput("final_q0_empty", 64'(q0.size()), 64'd0);
      checkOutput("final_q1_empty", 64'(q1.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
